// File: rtl/tlul_pkg.sv
// Shared TL-UL opcodes and arbiter state encoding.
package tlul_pkg;

  localparam logic [2:0] OPC_GET       = 3'b100;
  localparam logic [2:0] OPC_PUT_FULL  = 3'b000;
  localparam logic [2:0] OPC_ACK       = 3'b000;
  localparam logic [2:0] OPC_ACK_DATA  = 3'b001;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/tlul_rr_arb2.sv
// Two-way round-robin selector; last=0 means host1 was granted most recently.
module tlul_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  assign grant = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;

endmodule

// File: rtl/tlul_mem_arbiter.sv
// Two-host TL-UL arbiter in front of one memory port, one transaction in flight.
// Optional WAIT timeout with error response: define TLUL_ARB_TIMEOUT_EN.
//
// state     | meaning
// ARB_IDLE  | no transaction; grant a valid host and capture its request
// ARB_ISSUE | present the captured request on mem_a_* for one cycle
// ARB_WAIT  | wait for mem_d_valid_i and route the response to the owner
module tlul_mem_arbiter
  import tlul_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              h1_a_valid_i,
  input  logic [2:0]        h1_a_opcode_i,
  input  logic [ADDR_W-1:0] h1_a_address_i,
  input  logic [DATA_W-1:0] h1_a_data_i,
  output logic              h1_a_grant_o,
  output logic              h1_d_valid_o,
  output logic [2:0]        h1_d_opcode_o,
  output logic [DATA_W-1:0] h1_d_data_o,
  output logic              h1_d_error_o,
  input  logic              h2_a_valid_i,
  input  logic [2:0]        h2_a_opcode_i,
  input  logic [ADDR_W-1:0] h2_a_address_i,
  input  logic [DATA_W-1:0] h2_a_data_i,
  output logic              h2_a_grant_o,
  output logic              h2_d_valid_o,
  output logic [2:0]        h2_d_opcode_o,
  output logic [DATA_W-1:0] h2_d_data_o,
  output logic              h2_d_error_o,
  output logic              mem_a_valid_o,
  output logic [2:0]        mem_a_opcode_o,
  output logic [ADDR_W-1:0] mem_a_address_o,
  output logic [DATA_W-1:0] mem_a_data_o,
  input  logic              mem_d_valid_i,
  input  logic [2:0]        mem_d_opcode_i,
  input  logic [DATA_W-1:0] mem_d_data_i
);

  arb_state_e        state_q, state_d;
  logic              owner_q;
  logic              last_q;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic [1:0]        arb_req, rr_grant;
  logic              resp_valid, resp_err;
  logic [2:0]        resp_op;
  logic [DATA_W-1:0] resp_data;
  logic              h1_sel, h2_sel;

  // Grants are suppressed while reset is held so every output reads 0.
  assign arb_req = {h2_a_valid_i, h1_a_valid_i} & {2{(state_q == ARB_IDLE) && reset}};

  tlul_rr_arb2 u_rr (
    .req   (arb_req),
    .last  (last_q),
    .grant (rr_grant)
  );

  assign h1_a_grant_o = rr_grant[0];
  assign h2_a_grant_o = rr_grant[1];

`ifdef TLUL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ARB_ISSUE) begin
      tmo_cnt_q <= CNT_W'(TIMEOUT_CYCLES);
    end else if ((state_q == ARB_WAIT) && (tmo_cnt_q != '0)) begin
      tmo_cnt_q <= tmo_cnt_q - 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_op    = mem_d_opcode_i;
    resp_data  = mem_d_data_i;
    case (state_q)
      ARB_IDLE: begin
        if (|rr_grant) state_d = ARB_ISSUE;
      end
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (mem_d_valid_i) begin
          resp_valid = 1'b1;
          state_d    = ARB_IDLE;
        end
`ifdef TLUL_ARB_TIMEOUT_EN
        // A real response in the terminal-count cycle takes precedence.
        else if (tmo_cnt_q == '0) begin
          resp_valid = 1'b1;
          resp_err   = 1'b1;
          resp_op    = OPC_ACK_DATA;
          resp_data  = DATA_W'(TIMEOUT_DATA);
          state_d    = ARB_IDLE;
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ARB_IDLE) && (|rr_grant)) begin
        owner_q <= rr_grant[1];
        last_q  <= rr_grant[1];
        op_q    <= rr_grant[1] ? h2_a_opcode_i  : h1_a_opcode_i;
        addr_q  <= rr_grant[1] ? h2_a_address_i : h1_a_address_i;
        data_q  <= rr_grant[1] ? h2_a_data_i    : h1_a_data_i;
      end
    end
  end

  assign mem_a_valid_o   = (state_q == ARB_ISSUE);
  assign mem_a_opcode_o  = mem_a_valid_o ? op_q   : '0;
  assign mem_a_address_o = mem_a_valid_o ? addr_q : '0;
  assign mem_a_data_o    = mem_a_valid_o ? data_q : '0;

  assign h1_sel = resp_valid & ~owner_q;
  assign h2_sel = resp_valid &  owner_q;

  assign h1_d_valid_o  = h1_sel;
  assign h1_d_opcode_o = h1_sel ? resp_op   : '0;
  assign h1_d_data_o   = h1_sel ? resp_data : '0;
  assign h1_d_error_o  = h1_sel & resp_err;

  assign h2_d_valid_o  = h2_sel;
  assign h2_d_opcode_o = h2_sel ? resp_op   : '0;
  assign h2_d_data_o   = h2_sel ? resp_data : '0;
  assign h2_d_error_o  = h2_sel & resp_err;

endmodule

// File: tb/tb_tlul_mem_arbiter.sv
// Scoreboard bench for tlul_mem_arbiter: expected requests/responses queued, popped by monitors.
module tb_tlul_mem_arbiter;

`ifdef TLUL_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        h1_a_valid_i, h2_a_valid_i;
  logic [2:0]  h1_a_opcode_i, h2_a_opcode_i;
  logic [11:0] h1_a_address_i, h2_a_address_i;
  logic [31:0] h1_a_data_i, h2_a_data_i;
  logic        h1_a_grant_o, h2_a_grant_o;
  logic        h1_d_valid_o, h2_d_valid_o;
  logic [2:0]  h1_d_opcode_o, h2_d_opcode_o;
  logic [31:0] h1_d_data_o, h2_d_data_o;
  logic        h1_d_error_o, h2_d_error_o;
  logic        mem_a_valid_o;
  logic [2:0]  mem_a_opcode_o;
  logic [11:0] mem_a_address_o;
  logic [31:0] mem_a_data_o;
  logic        mem_d_valid_i;
  logic [2:0]  mem_d_opcode_i;
  logic [31:0] mem_d_data_i;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] data;
  } req_t;

  typedef struct {
    int          host;
    logic [2:0]  op;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  req_t mem_q[$];
  rsp_t rsp_q[$];

  tlul_mem_arbiter #(
    .ADDR_W         (12),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .h1_a_valid_i    (h1_a_valid_i),
    .h1_a_opcode_i   (h1_a_opcode_i),
    .h1_a_address_i  (h1_a_address_i),
    .h1_a_data_i     (h1_a_data_i),
    .h1_a_grant_o    (h1_a_grant_o),
    .h1_d_valid_o    (h1_d_valid_o),
    .h1_d_opcode_o   (h1_d_opcode_o),
    .h1_d_data_o     (h1_d_data_o),
    .h1_d_error_o    (h1_d_error_o),
    .h2_a_valid_i    (h2_a_valid_i),
    .h2_a_opcode_i   (h2_a_opcode_i),
    .h2_a_address_i  (h2_a_address_i),
    .h2_a_data_i     (h2_a_data_i),
    .h2_a_grant_o    (h2_a_grant_o),
    .h2_d_valid_o    (h2_d_valid_o),
    .h2_d_opcode_o   (h2_d_opcode_o),
    .h2_d_data_o     (h2_d_data_o),
    .h2_d_error_o    (h2_d_error_o),
    .mem_a_valid_o   (mem_a_valid_o),
    .mem_a_opcode_o  (mem_a_opcode_o),
    .mem_a_address_o (mem_a_address_o),
    .mem_a_data_o    (mem_a_data_o),
    .mem_d_valid_i   (mem_d_valid_i),
    .mem_d_opcode_i  (mem_d_opcode_i),
    .mem_d_data_i    (mem_d_data_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic any_out();
    return |{h1_a_grant_o, h2_a_grant_o, h1_d_valid_o, h2_d_valid_o, h1_d_opcode_o, h2_d_opcode_o,
             h1_d_data_o, h2_d_data_o, h1_d_error_o, h2_d_error_o, mem_a_valid_o, mem_a_opcode_o,
             mem_a_address_o, mem_a_data_o};
  endfunction

  always @(negedge clk) begin
    req_t r;
    rsp_t e;
    if (mem_a_valid_o) begin
      if (mem_q.size() == 0) chk("mem_unexpected", 1, 0);
      else begin
        r = mem_q.pop_front();
        chk("mem_opcode", mem_a_opcode_o, r.op);
        chk("mem_address", mem_a_address_o, r.addr);
        chk("mem_data", mem_a_data_o, r.data);
      end
    end
    if (h1_d_valid_o || h2_d_valid_o) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        e = rsp_q.pop_front();
        chk("rsp_h1_valid", h1_d_valid_o, e.host == 1);
        chk("rsp_h2_valid", h2_d_valid_o, e.host == 2);
        chk("rsp_opcode", (e.host == 1) ? h1_d_opcode_o : h2_d_opcode_o, e.op);
        chk("rsp_data", (e.host == 1) ? h1_d_data_o : h2_d_data_o, e.data);
        chk("rsp_error", (e.host == 1) ? h1_d_error_o : h2_d_error_o, e.err);
        chk("rsp_other_data", (e.host == 1) ? h2_d_data_o : h1_d_data_o, 0);
      end
    end
  end

  // Entered at posedge+1 of an IDLE cycle with host valids already driven.
  task automatic grant_and_issue(input int exp_host, input bit keep);
    req_t r;
    #2;
    chk("grant_h1", h1_a_grant_o, exp_host == 1);
    chk("grant_h2", h2_a_grant_o, exp_host == 2);
    r.op   = (exp_host == 1) ? h1_a_opcode_i  : h2_a_opcode_i;
    r.addr = (exp_host == 1) ? h1_a_address_i : h2_a_address_i;
    r.data = (exp_host == 1) ? h1_a_data_i    : h2_a_data_i;
    mem_q.push_back(r);
    @(posedge clk); #1;
    if (!keep) begin
      h1_a_valid_i = 1'b0;
      h2_a_valid_i = 1'b0;
    end
    mem_d_valid_i  = 1'b1;
    mem_d_opcode_i = 3'b001;
    mem_d_data_i   = 32'hBAD0_0BAD;
    #2;
    chk("issue_valid", mem_a_valid_o, 1);
    chk("issue_no_grant", h1_a_grant_o | h2_a_grant_o, 0);
    @(posedge clk); #1;
    mem_d_valid_i = 1'b0;
  endtask

  task automatic run_txn(input int exp_host, input int delay, input bit keep,
                         input logic [2:0] rop, input logic [31:0] rdata);
    rsp_t s;
    grant_and_issue(exp_host, keep);
    for (int i = 1; i < delay; i++) begin
      #2;
      chk("wait_quiet", {mem_a_valid_o, h1_a_grant_o, h2_a_grant_o, h1_d_valid_o, h2_d_valid_o}, 0);
      @(posedge clk); #1;
    end
    mem_d_valid_i  = 1'b1;
    mem_d_opcode_i = rop;
    mem_d_data_i   = rdata;
    s.host = exp_host;
    s.op   = rop;
    s.data = rdata;
    s.err  = 1'b0;
    rsp_q.push_back(s);
    #2;
    chk("resp_seen", h1_d_valid_o | h2_d_valid_o, 1);
    @(posedge clk); #1;
    mem_d_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset          = 1'b0;
    h1_a_valid_i   = 1'b1;
    h2_a_valid_i   = 1'b1;
    h1_a_opcode_i  = 3'b100;
    h2_a_opcode_i  = 3'b100;
    h1_a_address_i = 12'h000;
    h2_a_address_i = 12'h000;
    h1_a_data_i    = 32'h0;
    h2_a_data_i    = 32'h0;
    mem_d_valid_i  = 1'b1;
    mem_d_opcode_i = 3'b001;
    mem_d_data_i   = 32'h1234_5678;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", any_out(), 0);
    @(posedge clk); #1;
    reset         = 1'b1;
    h1_a_valid_i  = 1'b0;
    h2_a_valid_i  = 1'b0;
    #2;
    chk("idle_stray_rsp", any_out(), 0);
    @(posedge clk); #1;
    mem_d_valid_i = 1'b0;

    // Single Get from host1
    h1_a_valid_i   = 1'b1;
    h1_a_opcode_i  = 3'b100;
    h1_a_address_i = 12'h010;
    h1_a_data_i    = 32'h0;
    run_txn(1, 3, 1'b0, 3'b001, 32'h0050_0093);
    #2;
    chk("idle_after_get", any_out(), 0);
    @(posedge clk); #1;

    // Put from host2
    h2_a_valid_i   = 1'b1;
    h2_a_opcode_i  = 3'b000;
    h2_a_address_i = 12'h104;
    h2_a_data_i    = 32'hCAFE_0001;
    run_txn(2, 2, 1'b0, 3'b000, 32'h0);

    // Back-to-back: request presented in the cycle right after the response
    h1_a_valid_i   = 1'b1;
    h1_a_opcode_i  = 3'b010;
    h1_a_address_i = 12'hABC;
    h1_a_data_i    = 32'h0BAD_F00D;
    run_txn(1, 1, 1'b0, 3'b001, 32'h1111_2222);
    h1_a_valid_i   = 1'b1;
    h1_a_opcode_i  = 3'b100;
    h1_a_address_i = 12'h020;
    run_txn(1, 4, 1'b0, 3'b001, 32'h3333_4444);

    // Reset while host2 transaction is in WAIT
    h2_a_valid_i   = 1'b1;
    h2_a_opcode_i  = 3'b100;
    h2_a_address_i = 12'h200;
    h2_a_data_i    = 32'h0;
    grant_and_issue(2, 1'b0);
    @(posedge clk); #1;
    reset          = 1'b0;
    h1_a_valid_i   = 1'b1;
    mem_d_valid_i  = 1'b1;
    mem_d_opcode_i = 3'b001;
    mem_d_data_i   = 32'h5555_AAAA;
    #1;
    chk("reset_in_wait", any_out(), 0);
    @(posedge clk); #1;
    chk("reset_held", any_out(), 0);
    h1_a_valid_i = 1'b0;
    reset        = 1'b1;
    #2;
    chk("late_rsp_dropped", h1_d_valid_o | h2_d_valid_o, 0);
    @(posedge clk); #1;
    mem_d_valid_i = 1'b0;

    // Contention after reset: host2 first, then alternate
    h1_a_valid_i   = 1'b1;
    h1_a_opcode_i  = 3'b100;
    h1_a_address_i = 12'h030;
    h1_a_data_i    = 32'hAAAA_0001;
    h2_a_valid_i   = 1'b1;
    h2_a_opcode_i  = 3'b000;
    h2_a_address_i = 12'h040;
    h2_a_data_i    = 32'hBBBB_0002;
    run_txn(2, 2, 1'b1, 3'b000, 32'h0);
    run_txn(1, 1, 1'b1, 3'b001, 32'h6666_0001);
    run_txn(2, 3, 1'b1, 3'b000, 32'h0);
    run_txn(1, 2, 1'b0, 3'b001, 32'h6666_0002);
    #2;
    chk("idle_end_contention", any_out(), 0);
    @(posedge clk); #1;

`ifdef TLUL_ARB_TIMEOUT_EN
    begin
      rsp_t s;
      h1_a_valid_i   = 1'b1;
      h1_a_opcode_i  = 3'b100;
      h1_a_address_i = 12'h050;
      grant_and_issue(1, 1'b0);
      for (int i = 0; i < TMO; i++) begin
        #2;
        chk("tmo_quiet", h1_d_valid_o | h2_d_valid_o, 0);
        @(posedge clk); #1;
      end
      s.host = 1;
      s.op   = 3'b001;
      s.data = 32'hDEAD_BEEF;
      s.err  = 1'b1;
      rsp_q.push_back(s);
      #2;
      chk("tmo_seen", h1_d_error_o, 1);
      @(posedge clk); #1;
      mem_d_valid_i  = 1'b1;
      mem_d_opcode_i = 3'b001;
      mem_d_data_i   = 32'h7777_7777;
      #2;
      chk("tmo_late_ignored", h1_d_valid_o | h2_d_valid_o, 0);
      @(posedge clk); #1;
      mem_d_valid_i = 1'b0;
    end
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("mem_q_drained", mem_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tlul_mem_arbiter.md
TLUL_MEM_ARBITER -- requirements
Module: tlul_mem_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL take parameters: ADDR_W, 12, A-channel address width; DATA_W, 32, data width; TIMEOUT_CYCLES, 64, WAIT-state cycles before a timeout response.
REQ-003 SHALL have these ports (name  direction  width  meaning):
- clk  in  1  clock.
- reset  in  1  async active-low reset.
- h1_a_valid_i  in  1  host1 (fetch) request.
- h1_a_opcode_i  in  3  host1 opcode.
- h1_a_address_i  in  ADDR_W  host1 address.
- h1_a_data_i  in  DATA_W  host1 write data.
- h1_a_grant_o  out  1  host1 request accepted.
- h1_d_valid_o  out  1  host1 response valid.
- h1_d_opcode_o  out  3  host1 response opcode.
- h1_d_data_o  out  DATA_W  host1 response data.
- h1_d_error_o  out  1  host1 response error.
- h2_*  (same set as h1_*)  host2 (load/store) channel.
- mem_a_valid_o  out  1  request to memory.
- mem_a_opcode_o  out  3  forwarded opcode.
- mem_a_address_o  out  ADDR_W  forwarded address.
- mem_a_data_o  out  DATA_W  forwarded data.
- mem_d_valid_i  in  1  memory response valid.
- mem_d_opcode_i  in  3  memory response opcode.
- mem_d_data_i  in  DATA_W  memory response data.

Function
REQ-004 SHALL use opcodes Get=3'b100, PutFullData=3'b000, AccessAck=3'b000, AccessAckData=3'b001; other request opcodes SHALL be forwarded unchanged.
REQ-005 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE, with exactly one transaction outstanding.
REQ-006 IDLE: if any hN_a_valid_i=1, SHALL assert the winner's hN_a_grant_o combinationally in that cycle, capture its opcode/address/data and owner ID at the clock edge, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-007 Arbitration SHALL be round-robin: with only one host valid, that host wins; with both valid, the host not granted last wins; at most one grant per cycle.
REQ-008 ISSUE: SHALL drive mem_a_valid_o=1 with the captured fields for exactly one cycle, then go to WAIT.
REQ-009 WAIT: on mem_d_valid_i=1, SHALL pass opcode and data combinationally to the owner's d_* outputs with d_valid_o=1 and d_error_o=0 for that cycle, then go to IDLE.
REQ-010 The non-owner's d_valid_o SHALL be 0; mem_d_valid_i in IDLE or ISSUE SHALL be ignored.
REQ-011 Grant-to-response latency SHALL be at least 2 cycles; a new grant SHALL be possible in the cycle after a response.
REQ-012 Requests arriving in ISSUE/WAIT SHALL NOT be granted; a host SHALL hold valid and fields until granted.
REQ-013 When idle, mem_a_* and all hN_d_* outputs SHALL be 0.

Reset
REQ-014 While reset=0, SHALL go to IDLE, drive all outputs 0, clear captured registers, and set the last-granted pointer to host1 so host2 wins the first contention.
REQ-015 Reset during ISSUE/WAIT SHALL abort the transaction with no response; a later memory response SHALL be dropped.

Configuration
REQ-016 Macro TLUL_ARB_TIMEOUT_EN: when defined, a WAIT counter SHALL restart on WAIT entry; on reaching TIMEOUT_CYCLES with no mem_d_valid_i, SHALL pulse owner d_valid_o=1, d_opcode_o=AccessAckData, d_data_o=32'hDEAD_BEEF, d_error_o=1 for one cycle, then go to IDLE; a simultaneous real response SHALL win.
REQ-017 When TLUL_ARB_TIMEOUT_EN is undefined, SHALL have no counter, WAIT SHALL last until a response, and d_error_o SHALL be tied 0.

Structure
REQ-018 Opcode constants and the state enum (ARB_IDLE, ARB_ISSUE, ARB_WAIT) SHALL live in shared package tlul_pkg.
REQ-019 Round-robin selection SHALL be sub-module tlul_rr_arb2 (inputs: req[1:0], last; outputs: one-hot grant).

Verification
REQ-020 Single Get: h1 valid, address 12'h010; memory answers 3 cycles after ISSUE with 001/32'h00500093 -> h1_d_valid_o pulses once with that data; h2_d_valid_o stays 0.
REQ-021 Contention after reset: h1 and h2 valid at once -> h2 granted first, h1 next, alternating while both stay valid.
REQ-022 Put: h2 sends opcode 000, address 12'h104, data 32'hCAFE_0001 -> mem_a_* match for one cycle; response 000 is routed to h2.
REQ-023 Back-to-back requests: response cycle followed by h1 valid -> grant in the next cycle and mem_a_valid_o 2 cycles after the response.
REQ-024 With TLUL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8 and no response -> owner gets d_error_o=1 and data 32'hDEAD_BEEF 8 cycles after WAIT entry; a late response is ignored.
REQ-025 Reset asserted in WAIT -> all outputs 0 immediately; a response arriving after release produces no d_valid_o.
